// File: rtl/edge_gate.sv
// -----------------------------------------------------------------------------
// edge_gate
// Glitch-free clock gate that only ever passes whole clock pulses.
//
// Each channel's enable is captured on the falling edge of clk. The gated
// clock is clk ANDed with that captured value. The captured value only
// changes while clk is low, so a gated clock can never show a runt high or
// low phase. Enable activity that does not span a falling edge never reaches
// the output.
//
// Parameters:
//   CHANNELS     number of independent gated clock outputs (>= 1)
//
// Ports:
//   clk          source clock, 50% duty
//   rst          asynchronous, active-high reset; clears all captured enables
//   test_bypass  (only with EDGE_GATE_BYPASS_EN) static test control, forces
//                every clkout to follow clk, even during rst
//   en           per-channel enable request, asynchronous to the clk phase
//   clkout       gated clocks, one per channel
//   refclkout    ungated reference clock. It passes through the same gate
//                cell as a channel, so its insertion delay matches.
//
// Optional feature macro: EDGE_GATE_BYPASS_EN (adds the test_bypass port).
// -----------------------------------------------------------------------------
module edge_gate #(
  parameter int CHANNELS = 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef EDGE_GATE_BYPASS_EN
  input  logic                test_bypass,
`endif
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] clkout,
  output logic                refclkout
);

  // Captured enables. They may only change on a falling edge or on reset.
  logic [CHANNELS-1:0] en_q_r;
  // Constant-on gate enable for the reference path.
  logic                ref_en_s;
  // Bypass select shared by every gate cell. It is tied low when the feature
  // is absent.
  logic                bypass_s;

  // One gate cell: a bypass mux in front of an AND gate.
  // Channels and the reference both use this cell, so their paths match.
  function automatic logic gate_cell(input logic c, input logic g, input logic byp);
    logic o;
    if (byp) begin
      o = c;
    end else begin
      o = c & g;
    end
    return o;
  endfunction

`ifdef EDGE_GATE_BYPASS_EN
  assign bypass_s = test_bypass;
`else
  assign bypass_s = 1'b0;
`endif

  assign ref_en_s = 1'b1;

  // Capture enables on the falling edge so the AND gate only ever switches
  // while clk is low. Reset clears the captured enables at once.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      en_q_r <= {CHANNELS{1'b0}};
    end else begin
      en_q_r <= en;
    end
  end

  // Gate each channel. This path is intentionally combinational after the
  // capture flop: a registered output could not reproduce clk.
  always_comb begin
    clkout = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      clkout[i] = gate_cell(clk, en_q_r[i], bypass_s);
    end
  end

  // Reference clock through an identical, permanently enabled gate cell.
  always_comb begin
    refclkout = gate_cell(clk, ref_en_s, bypass_s);
  end

endmodule

// File: tb/tb_edge_gate.sv
`timescale 1ns/1ps
module tb_edge_gate;
  localparam int CH = 2;

  logic          clk;
  logic          rst;
  logic [CH-1:0] en;
  logic [CH-1:0] clkout;
  logic          refclkout;
`ifdef EDGE_GATE_BYPASS_EN
  logic          test_bypass;
`endif

  int checks   = 0;
  int failures = 0;

  edge_gate #(.CHANNELS(CH)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef EDGE_GATE_BYPASS_EN
    .test_bypass (test_bypass),
`endif
    .en          (en),
    .clkout      (clkout),
    .refclkout   (refclkout)
  );

  // 1000 ns period, high at t=0, falling edges at 500, 1500, ...
  initial begin
    clk = 1'b1;
    forever #500 clk = ~clk;
  end

  // Behavioural record of what each falling edge saw, and of reset activity.
  logic [CH-1:0] fall_en     = '0;
  logic          fall_rst    = 1'b1;
  longint        fall_t      = -1;
  longint        rst_rise_t  = -1;
  int            glitches    = 0;
  int            pulses0     = 0;

  always @(negedge clk) begin
    fall_en  = en;
    fall_rst = rst;
    fall_t   = longint'($time);
  end

  always @(posedge rst) rst_rise_t = longint'($time);

  // Outputs may only move on a clk edge. The one exception is an asynchronous
  // reset cutting a pulse short.
  always @(clkout or refclkout) begin
    if ((($time % 500) != 0) && !rst) glitches++;
  end

  always @(posedge clkout[0]) pulses0++;

  task automatic test_reset();
    rst = 1'b1;
    en  = '1;
    #250;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL reset_hi clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    checks++; if (refclkout !== 1'b1) begin failures++; $display("FAIL reset_ref_hi refclkout=%b exp=1", refclkout); end
    #500;
    checks++; if (refclkout !== 1'b0) begin failures++; $display("FAIL reset_ref_lo refclkout=%b exp=0", refclkout); end
    #500;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL reset_hold clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #50 rst = 1'b0;  // released at 1300 with en still high
    #450;            // 1750
    checks++; if (clkout !== '0) begin failures++; $display("FAIL reset_release_lo clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #500;            // 2250: falling edge at 1500 sampled en=1
    checks++; if (clkout !== '1) begin failures++; $display("FAIL reset_first_pulse clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #50 en = '0;
    #950;            // 3250
    checks++; if (clkout !== '0) begin failures++; $display("FAIL reset_stop clkout=%b exp=%b", clkout, {CH{1'b0}}); end
  endtask

  task automatic test_blips();
    @(posedge clk);
    #100 en = '1;    // blip inside the high phase
    #150;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL blip_hi_mid clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    checks++; if (refclkout !== 1'b1) begin failures++; $display("FAIL blip_ref refclkout=%b exp=1", refclkout); end
    #50  en = '0;
    #300 en = '1;    // blip inside the low phase
    #150;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL blip_lo_mid clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #50  en = '0;
    #450;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL blip_after clkout=%b exp=%b", clkout, {CH{1'b0}}); end
  endtask

  task automatic test_single_pulse();
    int p0;
    @(posedge clk);
    p0 = pulses0;
    en = '1;         // changes exactly at a rising edge
    #250;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL single_early clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #500;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL single_low clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #250 en = '0;    // dropped exactly at the next rising edge
    #250;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL single_pulse clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #500;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL single_pulse_low clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #500;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL single_none_after clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    checks++; if ((pulses0 - p0) !== 1) begin failures++; $display("FAIL single_count pulses=%0d exp=1", pulses0 - p0); end
  endtask

  task automatic test_hold();
    int p0;
    @(posedge clk);
    p0 = pulses0;
    #100  en = '1;
    #1000 en = '0;   // short low blip inside a high phase is ignored
    #150;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL hold_p1 clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #50   en = '1;
    #950;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL hold_p2 clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #350  en = '0;
    #650;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL hold_p3 clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #1000;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL hold_end clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    checks++; if ((pulses0 - p0) !== 3) begin failures++; $display("FAIL hold_count pulses=%0d exp=3", pulses0 - p0); end
  endtask

  task automatic test_reset_trunc();
    @(posedge clk);
    #100  en = '1;
    #1100 rst = 1'b1;  // 200 ns into a clkout pulse
    #1;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL trunc_cut clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #49;
    checks++; if (refclkout !== 1'b1) begin failures++; $display("FAIL trunc_ref refclkout=%b exp=1", refclkout); end
    #450  rst = 1'b0;
    #550;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL trunc_wait clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #1000;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL trunc_resume clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #100  en = '0;
    #900;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL trunc_stop clkout=%b exp=%b", clkout, {CH{1'b0}}); end
  endtask

`ifdef EDGE_GATE_BYPASS_EN
  task automatic test_bypass_mode();
    @(posedge clk);
    #750 begin test_bypass = 1'b1; rst = 1'b1; en = '0; end
    #500;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL bypass_hi clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #500;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL bypass_lo clkout=%b exp=%b", clkout, {CH{1'b0}}); end
    #50  begin rst = 1'b0; en = '1; end
    #450;
    checks++; if (clkout !== '1) begin failures++; $display("FAIL bypass_hi2 clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #500 test_bypass = 1'b0;
    #500;            // captured enable tracked en while bypassed
    checks++; if (clkout !== '1) begin failures++; $display("FAIL bypass_track clkout=%b exp=%b", clkout, {CH{1'b1}}); end
    #50  en = '0;
    #950;
    checks++; if (clkout !== '0) begin failures++; $display("FAIL bypass_off clkout=%b exp=%b", clkout, {CH{1'b0}}); end
  endtask
`endif

  task automatic test_random();
    logic [CH-1:0] exp_v;
    int            d;
    @(posedge clk);
    for (int c = 0; c < 300; c++) begin
      for (int w = 0; w < 4; w++) begin
        d = $urandom_range(1, 240);
        #d;
        if ($urandom_range(0, 1) == 0) en = CH'($urandom);
        if (rst) begin
          if ($urandom_range(0, 1) == 0) rst = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          rst = 1'b1;
        end
        #(250 - d);
        if (w == 0) begin
          // High phase: a channel is high only if the last falling edge saw
          // its enable with reset idle, and reset has not hit since.
          if (rst || fall_rst || (rst_rise_t > fall_t)) exp_v = '0;
          else exp_v = fall_en;
          checks++; if (clkout !== exp_v) begin failures++; $display("FAIL rand_hi cyc=%0d clkout=%b exp=%b", c, clkout, exp_v); end
          checks++; if (refclkout !== 1'b1) begin failures++; $display("FAIL rand_ref_hi cyc=%0d refclkout=%b exp=1", c, refclkout); end
        end else if (w == 2) begin
          checks++; if (clkout !== '0) begin failures++; $display("FAIL rand_lo cyc=%0d clkout=%b exp=%b", c, clkout, {CH{1'b0}}); end
          checks++; if (refclkout !== 1'b0) begin failures++; $display("FAIL rand_ref_lo cyc=%0d refclkout=%b exp=0", c, refclkout); end
        end
      end
    end
    #100 begin rst = 1'b0; en = '0; end
  endtask

  task automatic test_glitch_free();
    checks++; if (glitches !== 0) begin failures++; $display("FAIL glitch_free edges_off_clk=%0d exp=0", glitches); end
  endtask

  initial begin
`ifdef EDGE_GATE_BYPASS_EN
    test_bypass = 1'b0;
`endif
    test_reset();
    test_blips();
    test_single_pulse();
    test_hold();
    test_reset_trunc();
`ifdef EDGE_GATE_BYPASS_EN
    test_bypass_mode();
`endif
    test_random();
    test_glitch_free();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
